// File: rtl/iobuf_hd_ctrl.sv
// iobuf_hd_ctrl: sequencer for one tri-state pad buffer on a half-duplex,
// MSB-first serial link. Write commands drive the pad after a guard interval,
// read commands release it and sample pad_o at mid-bit. Every output is a
// register written by the single state machine below.
module iobuf_hd_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 8,
  parameter int TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              pad_i,
  output logic              pad_t,
  input  logic              pad_o
);

  localparam int TW = $clog2(TURN_CYC + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRV,
    S_TX,
    S_REL,
    S_RX,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_rd;
  logic [DIV_W-1:0]    r_div;
  logic [DATA_W-1:0]   r_sh;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic [TW-1:0]       r_turn;
  logic                r_pad_t;
  logic                r_pad_i;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_accept;
  logic                w_period_end;
  logic                w_sample;
  logic                w_last_bit;
  logic                w_turn_end;
  logic [DATA_W-1:0]   w_tx_next;
  logic [DATA_W-1:0]   w_rx_next;

  assign w_accept     = cmd_valid && r_cmd_ready;
  // Bit period is div+1 cycles: the counter runs 0..div, so div all-ones
  // simply reaches the top code and never wraps early.
  assign w_period_end = (r_div_cnt == r_div);
  // Mid-bit sample point sits at in-period offset floor(div/2).
  assign w_sample     = (r_div_cnt == (r_div >> 1));
  assign w_last_bit   = (r_bit_cnt == BIT_LAST);
  assign w_turn_end   = (r_turn == TURN_LAST);
  assign w_tx_next    = r_sh << 1;

  // Receive shift: new sample enters at the LSB so the first bit ends as MSB.
  generate
    if (DATA_W > 1) begin : g_rx_wide
      assign w_rx_next = {r_sh[DATA_W-2:0], pad_o};
    end else begin : g_rx_one
      assign w_rx_next = pad_o;
    end
  endgenerate

  // Transfer sequencer: state, counters, shift register and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pad_t     <= 1'b1;
      r_pad_i     <= 1'b1;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pad_t <= 1'b1;
          r_pad_i <= 1'b1;
          if (w_accept) begin
            // Command fields are captured here and never looked at again.
            r_rd        <= cmd_rd;
            r_div       <= div;
            r_sh        <= cmd_wdata;
            r_turn      <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_rd) begin
              r_state <= S_REL;
            end else begin
              r_state <= S_DRV;
              r_pad_t <= 1'b0;
            end
          end
        end

        S_DRV: begin
          // Own the line, idling high, before the first data bit.
          if (w_turn_end) begin
            r_state   <= S_TX;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_pad_i   <= r_sh[DATA_W-1];
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end

        S_TX: begin
          if (w_period_end) begin
            r_div_cnt <= '0;
            if (w_last_bit) begin
              r_state <= S_REL;
              r_rd    <= 1'b0;
              r_turn  <= '0;
              r_pad_t <= 1'b1;
              r_pad_i <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_sh      <= w_tx_next;
              r_pad_i   <= w_tx_next[DATA_W-1];
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_REL: begin
          // Line released; wait out the turnaround before reading or finishing.
          if (w_turn_end) begin
            if (r_rd) begin
              r_state   <= S_RX;
              r_div_cnt <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
            end
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end

        S_RX: begin
          if (w_sample) begin
            r_sh <= w_rx_next;
          end
          if (w_period_end) begin
            r_div_cnt <= '0;
            if (w_last_bit) begin
              // With div=0 the sample and period end share this cycle, so the
              // response takes the freshly shifted word.
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_sample ? w_rx_next : r_sh;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_pad_t     <= 1'b1;
          r_pad_i     <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_busy;
  assign pad_i     = r_pad_i;
  assign pad_t     = r_pad_t;

endmodule

// File: tb/tb_iobuf_hd_ctrl.sv
// Directed bench for iobuf_hd_ctrl: a table of write/read transactions with
// hand-computed response cycles, plus reset, back-to-back and abort sequences.
module tb_iobuf_hd_ctrl;

  localparam int DATA_W   = 8;
  localparam int DIV_W    = 8;
  localparam int TURN_CYC = 2;

  logic              clk;
  logic              rst;
  logic [DIV_W-1:0]  div;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rd;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              pad_i;
  logic              pad_t;
  logic              pad_o;

  int n_checks = 0;
  int n_fail   = 0;

  iobuf_hd_ctrl #(
    .DATA_W   (DATA_W),
    .DIV_W    (DIV_W),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .div       (div),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .pad_i     (pad_i),
    .pad_t     (pad_t),
    .pad_o     (pad_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] dv;
    logic [7:0] pword;
    logic       strict;
    logic       chg;
    logic [7:0] exp_rdata;
    int         exp_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Remote device model: drives pword MSB-first from cycle TURN_CYC+1, one bit
  // per div+1 cycles. In strict mode only the sample offset carries the bit.
  function automatic logic model_pad(input vec_t v, input int k);
    int p, j, b, off;
    logic bv;
    p = int'(v.dv) + 1;
    if (k <= TURN_CYC) return 1'b1;
    j   = k - TURN_CYC - 1;
    b   = j / p;
    off = j % p;
    if (b >= DATA_W) return 1'b1;
    bv = v.pword[7-b];
    if (v.strict && off != int'(v.dv) / 2) return ~bv;
    return bv;
  endfunction

  task automatic wait_ready(input string tag, output bit ok);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 100);
    if (!ok) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int  p, drv_end;
    bit  ok;
    logic exp_t, exp_i;
    string tag;
    tag = $sformatf("v%0d", idx);
    p = int'(v.dv) + 1;
    drv_end = TURN_CYC + DATA_W * p;
    wait_ready(tag, ok);
    if (!ok) return;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_rd    = v.rd;
    cmd_wdata = v.wdata;
    div       = v.dv;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (v.chg) begin
      div       = 8'd7;
      cmd_wdata = ~v.wdata;
      cmd_rd    = ~v.rd;
    end
    for (int k = 1; k <= v.exp_rsp + 1; k++) begin
      pad_o = v.rd ? model_pad(v, k) : 1'b1;
      @(negedge clk);
      if (!v.rd && k <= drv_end) exp_t = 1'b0;
      else exp_t = 1'b1;
      if (!v.rd && k > TURN_CYC && k <= drv_end) exp_i = v.wdata[7 - (k - TURN_CYC - 1) / p];
      else exp_i = 1'b1;
      check($sformatf("%s_pad_t_c%0d", tag, k), pad_t, exp_t);
      check($sformatf("%s_pad_i_c%0d", tag, k), pad_i, exp_i);
      check($sformatf("%s_rsp_valid_c%0d", tag, k), rsp_valid, (k == v.exp_rsp));
      check($sformatf("%s_busy_c%0d", tag, k), busy, (k <= v.exp_rsp));
      check($sformatf("%s_cmd_ready_c%0d", tag, k), cmd_ready, (k == v.exp_rsp + 1));
      if (k >= v.exp_rsp) check($sformatf("%s_rsp_rdata_c%0d", tag, k), rsp_rdata, v.exp_rdata);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit ok;
    vec_t tail;

    vecs[0] = '{rd:1'b0, wdata:8'hA5, dv:8'd0,   pword:8'h00, strict:1'b0, chg:1'b0, exp_rdata:8'h00, exp_rsp:13};
    vecs[1] = '{rd:1'b1, wdata:8'h00, dv:8'd3,   pword:8'h3C, strict:1'b0, chg:1'b0, exp_rdata:8'h3C, exp_rsp:35};
    vecs[2] = '{rd:1'b1, wdata:8'hFF, dv:8'd4,   pword:8'h96, strict:1'b1, chg:1'b0, exp_rdata:8'h96, exp_rsp:43};
    vecs[3] = '{rd:1'b0, wdata:8'h5C, dv:8'd2,   pword:8'h00, strict:1'b0, chg:1'b0, exp_rdata:8'h00, exp_rsp:29};
    vecs[4] = '{rd:1'b1, wdata:8'h00, dv:8'd0,   pword:8'h5A, strict:1'b1, chg:1'b0, exp_rdata:8'h5A, exp_rsp:11};
    vecs[5] = '{rd:1'b0, wdata:8'hC3, dv:8'd1,   pword:8'h00, strict:1'b0, chg:1'b1, exp_rdata:8'h00, exp_rsp:21};
    vecs[6] = '{rd:1'b1, wdata:8'h00, dv:8'd255, pword:8'h81, strict:1'b1, chg:1'b0, exp_rdata:8'h81, exp_rsp:2051};

    rst = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_wdata = '0; div = '0; pad_o = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held two cycles in idle while a command is offered.
    #1;
    rst = 1'b1; cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_wdata = 8'h0F;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst_pad_t_%0d", i), pad_t, 1);
      check($sformatf("rst_pad_i_%0d", i), pad_i, 1);
      check($sformatf("rst_cmd_ready_%0d", i), cmd_ready, 1);
      check($sformatf("rst_busy_%0d", i), busy, 0);
      check($sformatf("rst_rsp_valid_%0d", i), rsp_valid, 0);
      check($sformatf("rst_rsp_rdata_%0d", i), rsp_rdata, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_no_accept_busy", busy, 0);
    check("rst_no_accept_pad_t", pad_t, 1);

    for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

    // Back-to-back: write 0xFF, read held valid from the first busy cycle on.
    wait_ready("b2b", ok);
    if (ok) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_wdata = 8'hFF; div = 8'd0;
      @(posedge clk); #1;
      cmd_rd = 1'b1; pad_o = 1'b1;
      for (int k = 1; k <= 26; k++) begin
        @(negedge clk);
        check($sformatf("b2b_pad_t_c%0d", k), pad_t, (k <= 10) ? 0 : 1);
        check($sformatf("b2b_pad_i_c%0d", k), pad_i, 1);
        check($sformatf("b2b_rsp_valid_c%0d", k), rsp_valid, (k == 13 || k == 25));
        check($sformatf("b2b_cmd_ready_c%0d", k), cmd_ready, (k == 14 || k == 26));
        check($sformatf("b2b_busy_c%0d", k), busy, !(k == 14 || k == 26));
        if (k == 13) check("b2b_wr_rdata", rsp_rdata, 8'h00);
        if (k == 25) check("b2b_rd_rdata", rsp_rdata, 8'hFF);
        @(posedge clk); #1;
        if (k == 14) cmd_valid = 1'b0;
      end
    end

    // Reset during bit 3 of a write of 0x00: aborts with the pad released.
    wait_ready("abort", ok);
    if (ok) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_wdata = 8'h00; div = 8'd0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        check($sformatf("abort_pad_t_c%0d", k), pad_t, 0);
        if (k < 6) begin
          @(posedge clk); #1;
        end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_pad_t", pad_t, 1);
      check("abort_pad_i", pad_i, 1);
      check("abort_busy", busy, 0);
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_rsp_rdata", rsp_rdata, 0);
      for (int k = 0; k < 15; k++) begin
        check($sformatf("abort_no_rsp_%0d", k), rsp_valid, 0);
        @(negedge clk);
      end
      tail = '{rd:1'b0, wdata:8'h01, dv:8'd0, pword:8'h00, strict:1'b0, chg:1'b0, exp_rdata:8'h00, exp_rsp:13};
      run_txn(7, tail);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
